// File: rtl/register_file_if.sv
// Register file access bundle: two read ports and one write port.
// Master is the datapath side, slave is the register file.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] readAddr1;
  logic [ADDR_WIDTH-1:0] readAddr2;
  logic [ADDR_WIDTH-1:0] writeAddr;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  writeEnable;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;

  modport master (
    output readAddr1,
    output readAddr2,
    output writeAddr,
    output writeData,
    output writeEnable,
    input  readData1,
    input  readData2
  );

  modport slave (
    input  readAddr1,
    input  readAddr2,
    input  writeAddr,
    input  writeData,
    input  writeEnable,
    output readData1,
    output readData2
  );
endinterface

// File: rtl/register_file.sv
// MIPS GPR file: 2 combinational read ports, 1 sync write port,
// write-first bypass, $zero hard-wired to 0.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic           clock,
  input logic           reset,
  register_file_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wrHit;
  logic                  hit1;
  logic                  hit2;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  assign wrHit = rf.writeEnable && !reset
              && (rf.writeAddr != '0);
  assign hit1  = wrHit
              && (rf.readAddr1 == rf.writeAddr);
  assign hit2  = wrHit
              && (rf.readAddr2 == rf.writeAddr);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrHit) begin
      mem[rf.writeAddr] <= rf.writeData;
    end
  end

  // Address 0 and a bypass hit never coincide: a hit needs writeAddr != 0.
  always_comb begin
    rd1 = mem[rf.readAddr1];
    unique case (1'b1)
      (rf.readAddr1 == '0): rd1 = '0;
      hit1:                 rd1 = rf.writeData;
      default: ;
    endcase
  end

  always_comb begin
    rd2 = mem[rf.readAddr2];
    unique case (1'b1)
      (rf.readAddr2 == '0): rd2 = '0;
      hit2:                 rd2 = rf.writeData;
      default: ;
    endcase
  end

  assign rf.readData1 = rd1;
  assign rf.readData2 = rd2;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an array model.
module tb_register_file;
  logic clock;
  logic reset;
  int   errors;
  int   checks;
  logic modelValid;
  logic [31:0] model [32];

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .rf    (rf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rf.writeEnable && !reset && rf.writeAddr != 5'd0
        && rf.writeAddr == a) return rf.writeData;
    return model[a];
  endfunction

  // Architectural model: what the register file should hold.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
      modelValid <= 1'b1;
    end else if (rf.writeEnable && rf.writeAddr != 5'd0) begin
      model[rf.writeAddr] <= rf.writeData;
    end
  end

  always @(negedge clock) begin
    if (modelValid === 1'b1) begin
      check("port1", rf.readData1, expRead(rf.readAddr1));
      check("port2", rf.readData2, expRead(rf.readAddr2));
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf.writeEnable = 1'b1;
    rf.writeAddr   = a;
    rf.writeData   = d;
    cycle();
    rf.writeEnable = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    modelValid = 1'b0;
    reset = 1'b1;
    rf.readAddr1 = '0;
    rf.readAddr2 = '0;
    rf.writeAddr = '0;
    rf.writeData = '0;
    rf.writeEnable = 1'b0;
    cycle();
    reset = 1'b0;
    #2;
    check("reset_r0", rf.readData1, 32'h0);

    // Reset clear
    wr(5'd5, 32'hDEADBEEF);
    rf.readAddr1 = 5'd5;
    rf.readAddr2 = 5'd5;
    #2;
    check("pre_reset_r5", rf.readData1, 32'hDEADBEEF);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #2;
    check("rst_clr_p1", rf.readData1, 32'h0);
    check("rst_clr_p2", rf.readData2, 32'h0);

    // Basic write/read sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      rf.readAddr1 = 5'(i);
      rf.readAddr2 = 5'(31 - i);
      #2;
      check("sweep_p1", rf.readData1, 32'(i));
      check("sweep_p2", rf.readData2, 32'(31 - i));
    end

    // $zero protection
    rf.readAddr1 = 5'd0;
    rf.readAddr2 = 5'd0;
    rf.writeEnable = 1'b1;
    rf.writeAddr = 5'd0;
    rf.writeData = 32'hFFFFFFFF;
    #2;
    check("zero_nobyp", rf.readData1, 32'h0);
    cycle();
    rf.writeEnable = 1'b0;
    #2;
    check("zero_after", rf.readData2, 32'h0);

    // Bypass
    wr(5'd7, 32'h11111111);
    rf.writeAddr = 5'd7;
    rf.writeData = 32'h22222222;
    rf.readAddr1 = 5'd7;
    rf.readAddr2 = 5'd7;
    #2;
    check("nobyp_p1", rf.readData1, 32'h11111111);
    check("nobyp_p2", rf.readData2, 32'h11111111);
    rf.writeEnable = 1'b1;
    #2;
    check("byp_pre_p1", rf.readData1, 32'h22222222);
    check("byp_pre_p2", rf.readData2, 32'h22222222);
    cycle();
    rf.writeEnable = 1'b0;
    #2;
    check("byp_post_p1", rf.readData1, 32'h22222222);
    check("byp_post_p2", rf.readData2, 32'h22222222);

    // Reset vs write collision
    wr(5'd9, 32'h12345678);
    reset = 1'b1;
    rf.writeEnable = 1'b1;
    rf.writeAddr = 5'd9;
    rf.writeData = 32'hCAFEBABE;
    rf.readAddr1 = 5'd9;
    #2;
    check("coll_pre", rf.readData1, 32'h12345678);
    cycle();
    reset = 1'b0;
    rf.writeEnable = 1'b0;
    #2;
    check("coll_post", rf.readData1, 32'h0);

    // Independent ports
    wr(5'd3, 32'hAAAA5555);
    wr(5'd4, 32'h5555AAAA);
    rf.readAddr1 = 5'd3;
    rf.readAddr2 = 5'd4;
    rf.writeEnable = 1'b1;
    rf.writeAddr = 5'd4;
    rf.writeData = 32'h0F0F0F0F;
    #2;
    check("ind_pre_p1", rf.readData1, 32'hAAAA5555);
    check("ind_pre_p2", rf.readData2, 32'h0F0F0F0F);
    cycle();
    rf.writeEnable = 1'b0;
    #2;
    check("ind_post_p1", rf.readData1, 32'hAAAA5555);
    check("ind_post_p2", rf.readData2, 32'h0F0F0F0F);

    // Randomized traffic; narrow address range half the time for collisions
    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow = 1'($urandom_range(0, 1));
      rf.readAddr1 = narrow ? 5'($urandom_range(0, 3))
                            : 5'($urandom_range(0, 31));
      rf.readAddr2 = narrow ? 5'($urandom_range(0, 3))
                            : 5'($urandom_range(0, 31));
      rf.writeAddr = narrow ? 5'($urandom_range(0, 3))
                            : 5'($urandom_range(0, 31));
      rf.writeData = $urandom;
      rf.writeEnable = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 1'b0;
    rf.writeEnable = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

MIPS general-purpose register file for the CPU datapath: 32 × 32-bit registers, two combinational read ports feeding the ALU operand path, and one synchronous write port driven from write-back. It reads back what the single-word `Register` storage element only writes. A write-first bypass lets a decode-stage read see a value being written back in the same cycle. Register $zero is hard-wired to 0.

## Interface
- `DATA_WIDTH`, 32, register width in bits
- `ADDR_WIDTH`, 5, register index width; depth = 2**ADDR_WIDTH

- `clock`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high; clears every register
- `readAddr1`  input  ADDR_WIDTH  index for read port 1 (rs)
- `readAddr2`  input  ADDR_WIDTH  index for read port 2 (rt)
- `writeAddr`  input  ADDR_WIDTH  index for write port (rd/rt from write-back)
- `writeData`  input  DATA_WIDTH  value to write
- `writeEnable`  input  1  write strobe, sampled on rising edge
- `readData1`  output  DATA_WIDTH  contents selected by `readAddr1`
- `readData2`  output  DATA_WIDTH  contents selected by `readAddr2`

## Operation
- Storage: array of 2**ADDR_WIDTH words; entry 0 is never written and always reads 0.
- Write: on rising edge with `reset`=0, `writeEnable`=1 and `writeAddr`≠0, `writeData` is stored at `writeAddr`. `writeAddr`=0 writes are dropped silently.
- Read: `readDataN` is a combinational function of `readAddrN`, current array contents and the bypass condition; no read enable.
- Bypass (write-first): `readDataN` = `writeData` when `writeEnable`=1, `reset`=0, `writeAddr`≠0 and `readAddrN`=`writeAddr`. Otherwise it is the stored value.
- Address 0 override: `readAddrN`=0 always yields 0. This takes precedence over the bypass.
- Both ports may select the same address, and either or both may match `writeAddr`; each port resolves independently.
- Reset: with `reset`=1 at a rising edge, all entries become 0. A write presented in the same cycle is discarded. The bypass is disabled while `reset`=1.

## Timing
- Write latency: 1 clock. A value presented at edge N is readable from the array immediately after edge N. Through the bypass it is visible combinationally before edge N.
- Read latency: 0 clocks (combinational through address mux and bypass compare).
- Output reset values:
  - After the first rising edge with `reset`=1, `readData1` = `readData2` = 0 for any address.
  - Before the first reset edge, array contents are undefined. The bench must not check them.
- Reset mid-operation: reset has priority over any pending write. Contents written before the reset edge are lost.
- Back-to-back writes: successive writes to the same address on consecutive cycles are legal; the last one wins.
- No internal state other than the array, so there is no FSM. The design is the array, a write decoder, and two read muxes with compare logic.

## Test plan
- **Reset clear:** write 0xDEADBEEF to r5, then assert `reset` for 1 edge; read r5 on both ports -> 0x00000000.
- **Basic write/read:** write 0x00000001..0x0000001F to r1..r31 on consecutive edges; then sweep `readAddr1` 0..31 and `readAddr2` 31..0.
  - `readData1` = index for 1..31, and 0 for index 0.
  - `readData2` mirrors the same values in reverse order.
- **$zero protection:** `writeEnable`=1, `writeAddr`=0, `writeData`=0xFFFFFFFF, clock; read r0 -> 0. Also, during that write cycle with `readAddr1`=0 -> 0 (no bypass).
- **Bypass:** r7 holds 0x11111111.
  - Drive `writeAddr`=7, `writeData`=0x22222222, `writeEnable`=1, `readAddr1`=7, `readAddr2`=7 before the edge -> both ports show 0x22222222 pre-edge and after the edge.
  - With `writeEnable`=0 in the same setup -> both ports show 0x11111111.
- **Reset vs write collision:** r9 = 0x12345678. Assert `reset`=1 together with a write of 0xCAFEBABE to r9, with `readAddr1`=9.
  - Pre-edge: `readData1` = 0x12345678 (bypass off).
  - Post-edge: r9 = 0.
- **Independent ports:** r3 = 0xAAAA5555, r4 = 0x5555AAAA, `readAddr1`=3, `readAddr2`=4, write r4 = 0x0F0F0F0F in the same cycle.
  - Pre-edge: `readData1` = 0xAAAA5555, `readData2` = 0x0F0F0F0F.
  - After the edge, with the write deasserted, the values are unchanged.
